dqs_wr_gen: RTL and testbench

DQS_WR_GEN -- requirements
Module: dqs_wr_gen

---
 rtl/dqs_wr_gen_pkg.sv | 21 ++
 rtl/dqs_dci_ctrl.sv | 41 ++++
 rtl/dqs_wr_gen.sv | 128 ++++++++++++
 tb/tb_dqs_wr_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dqs_wr_gen_pkg.sv
// Shared types and DQS word constants for the DQS write-burst generator.
// Optional feature macro: DQS_WR_GEN_PRE2_EN (two-cycle preamble).
package dqs_wr_gen_pkg;

  // StPreHiz is only entered when the two-cycle preamble is built in.
  typedef enum logic [2:0] {
    StIdle,
    StPreHiz,
    StPre,
    StBurst,
    StPost
  } dqs_state_e;

  localparam logic [3:0] DqsWordIdle   = 4'b0000;  // idle / preamble / postamble data
  localparam logic [3:0] DqsWordToggle = 4'b0101;  // strobe toggle, bit 0 first
  localparam logic [3:0] TinAll        = 4'b1111;  // all bits high-Z
  localparam logic [3:0] TinDrive      = 4'b0000;  // all bits driven
  // First half of the word stays high-Z, second half starts driving low.
  localparam logic [3:0] TinPreHiz     = 4'b0011;

endpackage

// File: rtl/dqs_dci_ctrl.sv
// DCI termination control: keeps termination enabled while a read window is open
// in IDLE and for DciHold cycles after it closes. Output is registered.
module dqs_dci_ctrl
  import dqs_wr_gen_pkg::*;
#(
  parameter int unsigned DciHold = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle_i,       // IDLE and not leaving it this cycle
  input  logic rd_active_i,
  output logic dci_disable_o
);

  localparam logic [3:0] HoldInit = 4'(DciHold);

  logic [3:0] hold_q;
  logic       dci_disable_q;

  // Hold counter reloads while reading and counts down afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q        <= 4'd0;
      dci_disable_q <= 1'b1;
    end else if (!idle_i) begin
      hold_q        <= 4'd0;
      dci_disable_q <= 1'b1;
    end else if (rd_active_i) begin
      hold_q        <= HoldInit;
      dci_disable_q <= 1'b0;
    end else if (hold_q != 4'd0) begin
      hold_q        <= hold_q - 4'd1;
      dci_disable_q <= 1'b0;
    end else begin
      dci_disable_q <= 1'b1;
    end
  end

  assign dci_disable_o = dci_disable_q;

endmodule

// File: rtl/dqs_wr_gen.sv
// DQS write-burst generator: preamble, toggling burst, postamble, with
// seamless back-to-back chaining and DCI termination control.
// Optional feature macro: DQS_WR_GEN_PRE2_EN adds a leading half-high-Z
// preamble cycle, moving the first burst word one cycle later.
module dqs_wr_gen
  import dqs_wr_gen_pkg::*;
#(
  parameter int unsigned DCI_HOLD = 2,
  parameter int unsigned WORDS_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_start,
  input  logic [WORDS_W-1:0] wr_words,
  input  logic               rd_active,
  output logic [3:0]         din,
  output logic [3:0]         tin,
  output logic               dci_disable,
  output logic               busy,
  output logic               done
);

  dqs_state_e         state_q;
  logic [WORDS_W-1:0] cnt_q;
  logic [3:0]         din_q;
  logic [3:0]         tin_q;
  logic               busy_q;
  logic               done_q;
  logic [WORDS_W-1:0] load_words;
  logic               dci_idle;

  // A zero-length request still produces one burst word.
  assign load_words = (wr_words == '0) ? WORDS_W'(1) : wr_words;

  // A write accepted this cycle takes priority over read termination.
  assign dci_idle = (state_q == StIdle) && !wr_start;

  // Sequencer with registered outputs: outputs always describe state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      din_q   <= DqsWordIdle;
      tin_q   <= TinAll;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_start) begin
            cnt_q  <= load_words;
            din_q  <= DqsWordIdle;
            busy_q <= 1'b1;
`ifdef DQS_WR_GEN_PRE2_EN
            state_q <= StPreHiz;
            tin_q   <= TinPreHiz;
`else
            state_q <= StPre;
            tin_q   <= TinDrive;
`endif
          end else begin
            din_q  <= DqsWordIdle;
            tin_q  <= TinAll;
            busy_q <= 1'b0;
          end
        end
        StPreHiz: begin
          state_q <= StPre;
          din_q   <= DqsWordIdle;
          tin_q   <= TinDrive;
        end
        StPre: begin
          state_q <= StBurst;
          din_q   <= DqsWordToggle;
          tin_q   <= TinDrive;
        end
        StBurst: begin
          if (cnt_q <= WORDS_W'(1)) begin
            if (wr_start) begin
              // Chain the next burst without pre/postamble.
              cnt_q <= load_words;
              din_q <= DqsWordToggle;
            end else begin
              state_q <= StPost;
              cnt_q   <= '0;
              din_q   <= DqsWordIdle;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - WORDS_W'(1);
            din_q <= DqsWordToggle;
          end
          tin_q <= TinDrive;
        end
        StPost: begin
          state_q <= StIdle;
          din_q   <= DqsWordIdle;
          tin_q   <= TinAll;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          din_q   <= DqsWordIdle;
          tin_q   <= TinAll;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  dqs_dci_ctrl #(
    .DciHold(DCI_HOLD)
  ) u_dci_ctrl (
    .clk_i        (clk),
    .rst_i        (rst),
    .idle_i       (dci_idle),
    .rd_active_i  (rd_active),
    .dci_disable_o(dci_disable)
  );

  assign din  = din_q;
  assign tin  = tin_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dqs_wr_gen.sv
// Directed bench for dqs_wr_gen (default build, single-cycle preamble).
module tb_dqs_wr_gen;

  localparam int unsigned WordsW = 6;

  logic              clk;
  logic              rst;
  logic              wr_start;
  logic [WordsW-1:0] wr_words;
  logic              rd_active;
  logic [3:0]        din;
  logic [3:0]        tin;
  logic              dci_disable;
  logic              busy;
  logic              done;

  int checks;
  int errors;

  dqs_wr_gen #(
    .DCI_HOLD(2),
    .WORDS_W (WordsW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_start   (wr_start),
    .wr_words   (wr_words),
    .rd_active  (rd_active),
    .din        (din),
    .tin        (tin),
    .dci_disable(dci_disable),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then stable for sampling and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample n cycles starting with the current one, counting toggle words and done pulses.
  task automatic observe(input int n, output int tog, output int dn);
    tog = 0;
    dn  = 0;
    for (int i = 0; i < n; i++) begin
      if (din == 4'b0101 && tin == 4'b0000) tog++;
      if (done) dn++;
      step();
    end
  endtask

  int tog;
  int dn;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    wr_start  = 1'b1;   // coincident with reset, must be discarded
    wr_words  = 6'd3;
    rd_active = 1'b0;
    step();
    step();
    check_eq("rst_din", 32'(din), 32'h0);
    check_eq("rst_tin", 32'(tin), 32'hf);
    check_eq("rst_dci", 32'(dci_disable), 32'h1);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    rst      = 1'b0;
    wr_start = 1'b0;
    step();
    check_eq("idle_busy", 32'(busy), 32'h0);

    // Basic BL8 burst.
    wr_start = 1'b1;
    wr_words = 6'd2;
    step();
    wr_start = 1'b0;
    check_eq("pre_din", 32'(din), 32'h0);
    check_eq("pre_tin", 32'(tin), 32'h0);
    check_eq("pre_busy", 32'(busy), 32'h1);
    step();
    check_eq("b1_din", 32'(din), 32'h5);
    check_eq("b1_tin", 32'(tin), 32'h0);
    step();
    check_eq("b2_din", 32'(din), 32'h5);
    step();
    check_eq("post_din", 32'(din), 32'h0);
    check_eq("post_tin", 32'(tin), 32'h0);
    check_eq("post_done", 32'(done), 32'h1);
    step();
    check_eq("end_tin", 32'(tin), 32'hf);
    check_eq("end_busy", 32'(busy), 32'h0);
    check_eq("end_done", 32'(done), 32'h0);

    // Seamless chaining: 2 words then 3 words.
    wr_start = 1'b1;
    wr_words = 6'd2;
    step();
    wr_start = 1'b0;
    step();
    check_eq("ch_b1", 32'(din), 32'h5);
    step();
    check_eq("ch_b2", 32'(din), 32'h5);
    wr_start = 1'b1;
    wr_words = 6'd3;
    step();
    wr_start = 1'b0;
    observe(3, tog, dn);
    check_eq("ch_tog", 32'(tog), 32'd3);
    check_eq("ch_done_early", 32'(dn), 32'd0);
    check_eq("ch_post_done", 32'(done), 32'h1);
    check_eq("ch_post_din", 32'(din), 32'h0);
    step();
    observe(4, tog, dn);
    check_eq("ch_tail_tog", 32'(tog), 32'd0);
    check_eq("ch_tail_done", 32'(dn), 32'd0);
    check_eq("ch_idle", 32'(busy), 32'h0);

    // Requests during PRE and POST are ignored.
    wr_start = 1'b1;
    wr_words = 6'd1;
    step();
    wr_words = 6'd3;                // PRE: wr_start still high
    check_eq("ig_pre", 32'(tin), 32'h0);
    step();
    wr_start = 1'b0;                // last (only) BURST cycle: no chain
    check_eq("ig_burst", 32'(din), 32'h5);
    step();
    wr_start = 1'b1;                // POST
    check_eq("ig_post_done", 32'(done), 32'h1);
    step();
    wr_start = 1'b0;
    check_eq("ig_idle_busy", 32'(busy), 32'h0);
    observe(5, tog, dn);
    check_eq("ig_tog", 32'(tog), 32'd0);
    check_eq("ig_busy", 32'(busy), 32'h0);

    // DCI hold: rd_active high for 5 cycles in IDLE.
    check_eq("dci_pre", 32'(dci_disable), 32'h1);
    for (int i = 0; i < 12; i++) begin
      rd_active = (i < 5);
      check_eq($sformatf("dci_c%0d", i), 32'(dci_disable), (i >= 1 && i <= 7) ? 32'h0 : 32'h1);
      step();
    end

    // Write wins over read termination.
    rd_active = 1'b1;
    wr_start  = 1'b1;
    wr_words  = 6'd0;               // zero treated as one word
    step();
    rd_active = 1'b0;
    wr_start  = 1'b0;
    check_eq("ww_dci", 32'(dci_disable), 32'h1);
    check_eq("ww_busy", 32'(busy), 32'h1);
    observe(4, tog, dn);
    check_eq("w0_tog", 32'(tog), 32'd1);
    check_eq("w0_done", 32'(dn), 32'd1);
    check_eq("w0_dci", 32'(dci_disable), 32'h1);

    // Reset in the second BURST cycle of a 4-word burst.
    wr_start = 1'b1;
    wr_words = 6'd4;
    step();
    wr_start = 1'b0;
    step();
    step();
    check_eq("mr_b2", 32'(din), 32'h5);
    rst = 1'b1;
    step();
    check_eq("mr_tin", 32'(tin), 32'hf);
    check_eq("mr_din", 32'(din), 32'h0);
    check_eq("mr_busy", 32'(busy), 32'h0);
    check_eq("mr_done", 32'(done), 32'h0);
    rst = 1'b0;
    observe(6, tog, dn);
    check_eq("mr_tog", 32'(tog), 32'd0);
    check_eq("mr_dn", 32'(dn), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound in case the flow above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
